pe_unit: RTL and testbench

SIMD processing element; the consumer end of the fetch unit's PE interface. It takes pe_opcode, data_a and data_b, and performs element-wise ADD/SUB/MUL or a two-stage dot product. It returns stage-1 vectors and stage-2 scalars with valid pulses, plus store_result and stop strobes, back to the fetch unit.

---
 rtl/pe_pkg.sv | 22 ++
 rtl/pe_unit_if.sv | 31 +++
 rtl/pe_adder_tree.sv | 22 ++
 rtl/pe_unit.sv | 91 +++++++++
 tb/tb_pe_unit.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Opcode encoding and lane types shared by the PE and the fetch unit.
package pe_pkg;

  localparam int unsigned PE_OPCODE_LEN   = 4;
  localparam int unsigned PE_DATA_LEN     = 32;
  localparam int unsigned PE_NUM_ELEMENTS = 4;

  typedef enum logic [PE_OPCODE_LEN-1:0] {
    OP_NOP           = 4'd0,
    OP_ADD           = 4'd1,
    OP_SUB           = 4'd2,
    OP_MUL           = 4'd3,
    OP_DOTP          = 4'd4,
    OP_STORE_TEMP_S1 = 4'd5,
    OP_STORE_TEMP_S2 = 4'd6,
    OP_STORE_RESULT  = 4'd7,
    OP_STOP          = 4'd8
  } pe_op_e;

  typedef logic [PE_NUM_ELEMENTS-1:0][PE_DATA_LEN-1:0] pe_lanes_t;

endpackage

// File: rtl/pe_unit_if.sv
// Fetch-unit <-> PE bundle: operands and opcode in, results and strobes back.
interface pe_unit_if #(
  parameter int unsigned DATA_LEN      = 32,
  parameter int unsigned PE_ELEMENTS   = 4,
  parameter int unsigned PE_OPCODE_LEN = 4
);

  logic [PE_OPCODE_LEN-1:0]              pe_opcode;
  logic [PE_ELEMENTS-1:0][DATA_LEN-1:0]  data_a;
  logic [PE_ELEMENTS-1:0][DATA_LEN-1:0]  data_b;
  logic                                  pe_stage_1_valid;
  logic [PE_ELEMENTS-1:0][DATA_LEN-1:0]  pe_stage_1_output;
  logic                                  pe_stage_2_valid;
  logic [DATA_LEN-1:0]                   pe_stage_2_output;
  logic                                  store_result;
  logic                                  stop;
  logic                                  illegal_op;

  modport master (
    output pe_opcode, data_a, data_b,
    input  pe_stage_1_valid, pe_stage_1_output, pe_stage_2_valid,
           pe_stage_2_output, store_result, stop, illegal_op
  );

  modport slave (
    input  pe_opcode, data_a, data_b,
    output pe_stage_1_valid, pe_stage_1_output, pe_stage_2_valid,
           pe_stage_2_output, store_result, stop, illegal_op
  );

endinterface

// File: rtl/pe_adder_tree.sv
// Combinational balanced reduction of all lanes to one modulo-2^DATA_LEN sum.
module pe_adder_tree #(
  parameter int unsigned DATA_LEN    = 32,
  parameter int unsigned PE_ELEMENTS = 4
) (
  input  logic [PE_ELEMENTS-1:0][DATA_LEN-1:0] lanes,
  output logic [DATA_LEN-1:0]                  sum
);

  // Pairwise halving: each pass adds lane i+step into lane i.
  always_comb begin
    logic [DATA_LEN-1:0] acc [PE_ELEMENTS];
    for (int unsigned i = 0; i < PE_ELEMENTS; i++) acc[i] = lanes[i];
    for (int unsigned step = 1; step < PE_ELEMENTS; step = step * 2) begin
      for (int unsigned i = 0; i + step < PE_ELEMENTS; i = i + 2 * step) begin
        acc[i] = acc[i] + acc[i + step];
      end
    end
    sum = acc[0];
  end

endmodule

// File: rtl/pe_unit.sv
// SIMD processing element: lane-wise ADD/SUB/MUL, two-stage dot product,
// and the store/stop strobes returned to the fetch unit.
module pe_unit #(
  parameter int unsigned DATA_LEN      = 32,
  parameter int unsigned PE_ELEMENTS   = 4,
  parameter int unsigned PE_OPCODE_LEN = 4
) (
  input logic     clk,
  input logic     rstn,
  pe_unit_if.slave pe
);

  import pe_pkg::*;

  typedef logic [PE_ELEMENTS-1:0][DATA_LEN-1:0] lanes_t;

  pe_op_e              op;
  lanes_t              add_v, sub_v, mul_v;
  lanes_t              s1_reg;
  logic [DATA_LEN-1:0] s2_reg;
  logic [DATA_LEN-1:0] tree_sum;
  logic                dotp_pending;

  assign op = pe_op_e'(pe.pe_opcode);

  always_comb begin
    add_v = '0;
    sub_v = '0;
    mul_v = '0;
    for (int unsigned i = 0; i < PE_ELEMENTS; i++) begin
      add_v[i] = pe.data_a[i] + pe.data_b[i];
      sub_v[i] = pe.data_a[i] - pe.data_b[i];
      mul_v[i] = pe.data_a[i] * pe.data_b[i];
    end
  end

  pe_adder_tree #(
    .DATA_LEN    (DATA_LEN),
    .PE_ELEMENTS (PE_ELEMENTS)
  ) u_adder_tree (
    .lanes (s1_reg),
    .sum   (tree_sum)
  );

  // Stage 2 runs off dotp_pending independently of the current opcode, so a
  // stage-1 write issued right after DOTP cannot disturb the pending sum.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_reg               <= '0;
      s2_reg               <= '0;
      dotp_pending         <= 1'b0;
      pe.pe_stage_1_valid  <= 1'b0;
      pe.pe_stage_1_output <= '0;
      pe.pe_stage_2_valid  <= 1'b0;
      pe.pe_stage_2_output <= '0;
      pe.store_result      <= 1'b0;
      pe.stop              <= 1'b0;
      pe.illegal_op        <= 1'b0;
    end else begin
      pe.pe_stage_1_valid <= 1'b0;
      pe.pe_stage_2_valid <= 1'b0;
      pe.store_result     <= 1'b0;
      pe.stop             <= 1'b0;
      dotp_pending        <= 1'b0;
      if (dotp_pending) s2_reg <= tree_sum;

      case (op)
        OP_NOP: ;
        OP_ADD: s1_reg <= add_v;
        OP_SUB: s1_reg <= sub_v;
        OP_MUL: s1_reg <= mul_v;
        OP_DOTP: begin
          s1_reg       <= mul_v;
          dotp_pending <= 1'b1;
        end
        OP_STORE_TEMP_S1: begin
          pe.pe_stage_1_valid  <= 1'b1;
          pe.pe_stage_1_output <= s1_reg;
        end
        OP_STORE_TEMP_S2: begin
          pe.pe_stage_2_valid  <= 1'b1;
          pe.pe_stage_2_output <= dotp_pending ? tree_sum : s2_reg;
        end
        OP_STORE_RESULT: pe.store_result <= 1'b1;
        OP_STOP:         pe.stop         <= 1'b1;
        default:         pe.illegal_op   <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_unit.sv
// Directed-vector bench for pe_unit with hand-computed expectations.
module tb_pe_unit;

  import pe_pkg::*;

  localparam int unsigned DL = 32;
  localparam int unsigned NE = 4;

  logic clk;
  logic rstn;
  int   n_tests;
  int   n_failed;

  pe_unit_if #(.DATA_LEN(DL), .PE_ELEMENTS(NE), .PE_OPCODE_LEN(4)) bus ();

  pe_unit #(
    .DATA_LEN      (DL),
    .PE_ELEMENTS   (NE),
    .PE_OPCODE_LEN (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .pe   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic pe_lanes_t vec(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Drive at a falling edge; outputs produced by the next rising edge are
  // visible when this returns at the following falling edge.
  task automatic cyc(input logic [3:0] op);
    bus.pe_opcode = op;
    @(negedge clk);
  endtask

  task automatic operands(input pe_lanes_t a, input pe_lanes_t b);
    bus.data_a = a;
    bus.data_b = b;
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    rstn = 1'b0;
    bus.pe_opcode = 4'd0;
    bus.data_a = '0;
    bus.data_b = '0;
    @(negedge clk);

    cyc(OP_NOP);
    cyc(OP_NOP);
    rstn = 1'b1;
    cyc(OP_NOP);
    check("rst_s1_valid", 128'(bus.pe_stage_1_valid), 128'(0));
    check("rst_s1_out",   128'(bus.pe_stage_1_output), 128'(0));
    check("rst_s2_valid", 128'(bus.pe_stage_2_valid), 128'(0));
    check("rst_s2_out",   128'(bus.pe_stage_2_output), 128'(0));
    check("rst_store",    128'(bus.store_result), 128'(0));
    check("rst_stop",     128'(bus.stop), 128'(0));
    check("rst_illegal",  128'(bus.illegal_op), 128'(0));

    operands(vec(1, 2, 3, 4), vec(10, 20, 30, 40));
    cyc(OP_ADD);
    check("add_no_valid", 128'(bus.pe_stage_1_valid), 128'(0));
    cyc(OP_STORE_TEMP_S1);
    check("add_valid", 128'(bus.pe_stage_1_valid), 128'(1));
    check("add_out",   128'(bus.pe_stage_1_output), 128'(vec(11, 22, 33, 44)));
    cyc(OP_NOP);
    check("s1_pulse_end", 128'(bus.pe_stage_1_valid), 128'(0));
    check("s1_out_hold",  128'(bus.pe_stage_1_output), 128'(vec(11, 22, 33, 44)));

    operands(vec(0, 5, 9, 100), vec(1, 2, 9, 1));
    cyc(OP_SUB);
    cyc(OP_STORE_TEMP_S1);
    check("sub_wrap", 128'(bus.pe_stage_1_output), 128'(vec(32'hFFFF_FFFF, 3, 0, 99)));

    operands(vec(32'h1_0000, 3, 32'hFFFF_FFFF, 32'h8000),
             vec(32'h1_0000, 7, 2, 32'h2_0000));
    cyc(OP_MUL);
    cyc(OP_STORE_TEMP_S1);
    check("mul_wrap", 128'(bus.pe_stage_1_output), 128'(vec(0, 21, 32'hFFFF_FFFE, 0)));

    // Dot product with a NOP gap: 2*1+2*2+2*3+2*4 = 20.
    operands(vec(2, 2, 2, 2), vec(1, 2, 3, 4));
    cyc(OP_DOTP);
    cyc(OP_NOP);
    cyc(OP_STORE_TEMP_S2);
    check("dotp20_valid", 128'(bus.pe_stage_2_valid), 128'(1));
    check("dotp20_out",   128'(bus.pe_stage_2_output), 128'(20));
    cyc(OP_NOP);
    check("s2_pulse_end", 128'(bus.pe_stage_2_valid), 128'(0));

    operands(vec(1, 2, 3, 4), vec(5, 6, 7, 8));
    cyc(OP_DOTP);
    cyc(OP_NOP);
    cyc(OP_STORE_TEMP_S2);
    check("dotp70_nop", 128'(bus.pe_stage_2_output), 128'(70));

    operands(vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF), vec(1, 1, 1, 1));
    cyc(OP_DOTP);
    cyc(OP_NOP);
    cyc(OP_STORE_TEMP_S2);
    check("dotp_wrap", 128'(bus.pe_stage_2_output), 128'(32'hFFFF_FFFC));

    // ADD right after DOTP overwrites s1 but the sum still uses the products.
    operands(vec(1, 2, 3, 4), vec(5, 6, 7, 8));
    cyc(OP_DOTP);
    cyc(OP_ADD);
    cyc(OP_STORE_TEMP_S2);
    check("dotp70_add", 128'(bus.pe_stage_2_output), 128'(70));
    cyc(OP_STORE_TEMP_S1);
    check("add_after_dotp", 128'(bus.pe_stage_1_output), 128'(vec(6, 8, 10, 12)));

    cyc(OP_STORE_RESULT);
    check("sr_pulse",  128'(bus.store_result), 128'(1));
    check("sr_nostop", 128'(bus.stop), 128'(0));
    cyc(OP_STOP);
    check("stop_sr_low", 128'(bus.store_result), 128'(0));
    check("stop_pulse",  128'(bus.stop), 128'(1));
    cyc(OP_NOP);
    check("stop_end", 128'(bus.stop), 128'(0));
    cyc(OP_STORE_RESULT);
    cyc(OP_STORE_RESULT);
    check("sr_repeat", 128'(bus.store_result), 128'(1));
    cyc(OP_NOP);
    check("sr_repeat_end", 128'(bus.store_result), 128'(0));

    check("illegal_before", 128'(bus.illegal_op), 128'(0));
    cyc(4'd12);
    check("illegal_set", 128'(bus.illegal_op), 128'(1));
    cyc(OP_NOP);
    cyc(OP_STORE_TEMP_S1);
    check("illegal_sticky", 128'(bus.illegal_op), 128'(1));
    check("illegal_keeps_s1", 128'(bus.pe_stage_1_output), 128'(vec(6, 8, 10, 12)));

    // Reset lands while the dot-product sum is still pending.
    operands(vec(1, 2, 3, 4), vec(5, 6, 7, 8));
    cyc(OP_DOTP);
    rstn = 1'b0;
    cyc(OP_NOP);
    rstn = 1'b1;
    cyc(OP_NOP);
    check("illegal_cleared", 128'(bus.illegal_op), 128'(0));
    cyc(OP_NOP);
    cyc(OP_STORE_TEMP_S2);
    check("post_rst_s2_valid", 128'(bus.pe_stage_2_valid), 128'(1));
    check("post_rst_s2_out",   128'(bus.pe_stage_2_output), 128'(0));
    cyc(OP_STORE_TEMP_S1);
    check("post_rst_s1_out", 128'(bus.pe_stage_1_output), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
